// File: rtl/clock_step_ctrl_if.sv
// clock_step_ctrl_if: mode controls in, tick/status out; master drives controls, slave is the controller
interface clock_step_ctrl_if #(parameter int CNT_W = 16);
  logic hzX;
  logic run_sw;
  logic step_btn;
  logic halt_req;
  logic resume;
  logic tick;
  logic [1:0] state;
  logic halted;
  logic stalled;
  logic [CNT_W-1:0] tick_count;
  modport master(output hzX, run_sw, step_btn, halt_req, resume,
                 input tick, state, halted, stalled, tick_count);
  modport slave(input hzX, run_sw, step_btn, halt_req, resume,
                output tick, state, halted, stalled, tick_count);
endinterface

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: turns divided-clock rises into one-cycle CPU ticks (run/step/halt)
// Optional step_btn debounce when STEP_DEBOUNCE_EN is defined.
module clock_step_ctrl #(
  parameter int CNT_W = 16,
  parameter int STALL_LIMIT = 255,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  clock_step_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {RUN = 2'b00, MANUAL = 2'b01, STEP = 2'b10, HALT = 2'b11} state_t;
  if (STALL_LIMIT < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("clock_step_ctrl: STALL_LIMIT and DEBOUNCE_CYCLES must be >= 1");
  end
  state_t cur, nxt;
  logic hz_prev, btn_q, press, rise, active;
  logic tick_q, tick_d, halted_q, stalled_q;
  logic [WD_W-1:0] wd, wd_d;
  logic [CNT_W-1:0] cnt;
  assign rise = bus.hzX & ~hz_prev;
  assign active = cur == RUN || cur == STEP;
`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DB_W-1:0] db_cnt;
  // counter saturates so a long hold yields exactly one press
  always_ff @(posedge clk)
    if (!rst) begin
      btn_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      btn_q <= bus.step_btn;
      db_cnt <= !btn_q ? '0 : db_cnt == DB_W'(DEBOUNCE_CYCLES) ? db_cnt : db_cnt + 1'b1;
    end
  assign press = btn_q && db_cnt == DB_W'(DEBOUNCE_CYCLES - 1);
`else
  logic btn_prev;
  always_ff @(posedge clk)
    if (!rst) begin
      btn_q <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_q <= bus.step_btn;
      btn_prev <= btn_q;
    end
  assign press = btn_q & ~btn_prev;
`endif
  always_ff @(posedge clk)
    cur <= !rst ? MANUAL : nxt;
  always_comb
    nxt = bus.halt_req ? HALT :
          cur == HALT ? (bus.resume ? (bus.run_sw ? RUN : MANUAL) : HALT) :
          cur == MANUAL ? (bus.run_sw ? RUN : press ? STEP : MANUAL) :
          cur == STEP ? (rise ? MANUAL : bus.run_sw ? RUN : STEP) :
          (bus.run_sw ? RUN : MANUAL);
  always_comb begin
    tick_d = !bus.halt_req && rise && active;
    wd_d = active && !rise ? (wd == WD_W'(STALL_LIMIT) ? wd : wd + 1'b1) : '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      hz_prev <= 1'b1;
      tick_q <= 1'b0;
      halted_q <= 1'b0;
      stalled_q <= 1'b0;
      wd <= '0;
      cnt <= '0;
    end else begin
      hz_prev <= bus.hzX;
      tick_q <= tick_d;
      halted_q <= nxt == HALT;
      stalled_q <= wd_d == WD_W'(STALL_LIMIT);
      wd <= wd_d;
      cnt <= cnt + CNT_W'(tick_d);
    end
  assign bus.tick = tick_q;
  assign bus.state = cur;
  assign bus.halted = halted_q;
  assign bus.stalled = stalled_q;
  assign bus.tick_count = cnt;
endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed plus random stimulus checked against a cycle reference model
module tb_clock_step_ctrl;
  localparam int CW = 4;
  localparam int LIM = 4;
  localparam int DEB = 4;
`ifdef STEP_DEBOUNCE_EN
  localparam int PRESS_N = DEB;
`else
  localparam int PRESS_N = 1;
`endif
  localparam int S_RUN = 0, S_MAN = 1, S_STP = 2, S_HLT = 3;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0, n_err = 0;
  int ticks_seen = 0, steps_seen = 0, prev_state = S_MAN;
  int m_state, m_cnt, m_wd, m_run;
  bit m_tick, m_hz_prev;
  clock_step_ctrl_if #(.CNT_W(CW)) bus ();
  clock_step_ctrl #(.CNT_W(CW), .STALL_LIMIT(LIM), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: advances the spec's rules for one clk edge from the current inputs
  task automatic step_model();
    bit rise, press, act;
    int ns;
    if (!rst) begin
      m_state = S_MAN; m_tick = 0; m_cnt = 0; m_wd = 0; m_hz_prev = 1; m_run = 0;
    end else begin
      rise = bus.hzX && !m_hz_prev;
      press = m_run == PRESS_N;
      act = m_state == S_RUN || m_state == S_STP;
      m_tick = act && rise && !bus.halt_req;
      if (bus.halt_req) ns = S_HLT;
      else if (m_state == S_HLT) ns = bus.resume ? (bus.run_sw ? S_RUN : S_MAN) : S_HLT;
      else if (m_state == S_MAN) ns = bus.run_sw ? S_RUN : (press ? S_STP : S_MAN);
      else if (m_state == S_STP) ns = rise ? S_MAN : (bus.run_sw ? S_RUN : S_STP);
      else ns = bus.run_sw ? S_RUN : S_MAN;
      m_state = ns;
      m_cnt = (m_cnt + int'(m_tick)) % (1 << CW);
      m_wd = (act && !rise) ? (m_wd < LIM ? m_wd + 1 : LIM) : 0;
      m_hz_prev = bus.hzX;
      m_run = bus.step_btn ? (m_run < 1000 ? m_run + 1 : m_run) : 0;
    end
  endtask

  task automatic cyc();
    step_model();
    @(posedge clk);
    #1;
    chk("tick", bus.tick, m_tick);
    chk("state", bus.state, m_state);
    chk("halted", bus.halted, m_state == S_HLT);
    chk("stalled", bus.stalled, m_wd == LIM);
    chk("tick_count", bus.tick_count, m_cnt);
    if (bus.tick) ticks_seen++;
    if (bus.state == S_STP && prev_state != S_STP) steps_seen++;
    prev_state = bus.state;
  endtask

  initial begin
    rst = 1'b0;
    bus.hzX = 1'b1; bus.run_sw = 1'b1; bus.step_btn = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
    repeat (3) cyc();
    chk("reset_state", bus.state, S_MAN);
    chk("reset_count", bus.tick_count, 0);
    rst = 1'b1;
    cyc();
    chk("release_no_tick", bus.tick, 0);
    bus.hzX = 1'b0; cyc();
    bus.hzX = 1'b1; cyc();
    chk("first_tick", bus.tick, 1);
    chk("first_count", bus.tick_count, 1);
    ticks_seen = 0;
    repeat (10) begin
      bus.hzX = 1'b0; repeat (4) cyc();
      bus.hzX = 1'b1; repeat (4) cyc();
    end
    chk("freerun_ticks", ticks_seen, 10);
    bus.run_sw = 1'b0; bus.hzX = 1'b0; cyc();
    ticks_seen = 0;
    repeat (3) begin
      bus.step_btn = 1'b1; repeat (PRESS_N + 2) cyc();
      bus.step_btn = 1'b0;
      chk("step_entered", bus.state, S_STP);
      bus.hzX = 1'b1; cyc();
      chk("step_tick", bus.tick, 1);
      bus.hzX = 1'b0; cyc();
      chk("step_back_manual", bus.state, S_MAN);
    end
    chk("manual_ticks", ticks_seen, 3);
    repeat (3) begin
      bus.hzX = 1'b1; repeat (2) cyc();
      bus.hzX = 1'b0; repeat (2) cyc();
    end
    chk("no_press_ticks", ticks_seen, 3);
    bus.run_sw = 1'b1; cyc();
    bus.hzX = 1'b1; bus.halt_req = 1'b1; cyc();
    chk("halt_no_tick", bus.tick, 0);
    chk("halt_halted", bus.halted, 1);
    bus.hzX = 1'b0; bus.resume = 1'b1; cyc();
    chk("halt_beats_resume", bus.state, S_HLT);
    bus.halt_req = 1'b0; cyc();
    chk("resume_run", bus.state, S_RUN);
    bus.resume = 1'b0;
    repeat (3) cyc();
    chk("not_yet_stalled", bus.stalled, 0);
    cyc();
    chk("stalled", bus.stalled, 1);
    bus.hzX = 1'b1; cyc();
    chk("stall_cleared", bus.stalled, 0);
    bus.run_sw = 1'b0; bus.hzX = 1'b0; cyc();
    bus.step_btn = 1'b1; repeat (PRESS_N + 2) cyc();
    bus.step_btn = 1'b0;
    chk("pre_reset_step", bus.state, S_STP);
    rst = 1'b0; cyc();
    chk("mid_reset_state", bus.state, S_MAN);
    chk("mid_reset_count", bus.tick_count, 0);
    rst = 1'b1; bus.run_sw = 1'b1; cyc();
    repeat (17) begin
      bus.hzX = 1'b0; repeat (2) cyc();
      bus.hzX = 1'b1; repeat (2) cyc();
    end
    chk("wrap_count", bus.tick_count, 1);
`ifdef STEP_DEBOUNCE_EN
    bus.run_sw = 1'b0; bus.hzX = 1'b0; repeat (2) cyc();
    steps_seen = 0;
    bus.step_btn = 1'b1; repeat (3) cyc();
    bus.step_btn = 1'b0; repeat (6) cyc();
    chk("debounce_short", steps_seen, 0);
    bus.step_btn = 1'b1; repeat (6) cyc();
    bus.step_btn = 1'b0; repeat (4) cyc();
    chk("debounce_long", steps_seen, 1);
`endif
    repeat (3000) begin
      if ($urandom_range(3) == 0) bus.hzX = ~bus.hzX;
      if ($urandom_range(39) == 0) bus.run_sw = ~bus.run_sw;
      if ($urandom_range(5) == 0) bus.step_btn = ~bus.step_btn;
      bus.halt_req = $urandom_range(29) == 0;
      bus.resume = $urandom_range(7) == 0;
      rst = $urandom_range(499) != 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
